avalon_debounced_pio: RTL and testbench



---
 rtl/avalon_debounced_pio_pkg.sv | 37 +++
 rtl/avalon_debounced_pio_if.sv | 35 +++
 rtl/pio_debounce_bit.sv | 57 +++++
 rtl/avalon_debounced_pio.sv | 146 ++++++++++++++
 tb/tb_avalon_debounced_pio.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_debounced_pio_pkg.sv
// -----------------------------------------------------------------------------
// avalon_pio_pkg
// Shared definitions for the debounced Avalon-MM PIO input block: data-bus
// width, word addresses of the register map and an enum naming each slot.
// No ports; imported by the interface, the top and the testbench.
// -----------------------------------------------------------------------------
package avalon_pio_pkg;

  // Avalon data bus and address widths
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  // Word addresses of the register map
  localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_RAW     = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_COUNT   = 3'd4;

  // Every 3-bit address maps onto one enum value so the cast is total
  typedef enum logic [ADDR_W-1:0] {
    REG_DATA    = ADDR_DATA,
    REG_IRQMASK = ADDR_IRQMASK,
    REG_EDGE    = ADDR_EDGE,
    REG_RAW     = ADDR_RAW,
    REG_COUNT   = ADDR_COUNT,
    REG_RSVD5   = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } regsel_e;

  // Turn a raw word address into a register selector
  function automatic regsel_e decodeAddr(input logic [ADDR_W-1:0] addr);
    return regsel_e'(addr);
  endfunction

endpackage

// File: rtl/avalon_debounced_pio_if.sv
// -----------------------------------------------------------------------------
// avalon_debounced_pio_if
// Avalon-MM bus bundle between the Nios II master and the PIO responder.
// Signals:
//   avs_chipselect     slave select
//   avs_address        word address (3 bits)
//   avs_read           read strobe
//   avs_write          write strobe
//   avs_writedata      write data (32 bits)
//   avs_readdata       registered read data (32 bits)
//   avs_readdatavalid  one-cycle pulse qualifying avs_readdata
// Modports: master drives the request side, slave drives the response side.
// -----------------------------------------------------------------------------
interface avalon_debounced_pio_if;
  import avalon_pio_pkg::*;

  logic              avs_chipselect;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;

  modport master (
    output avs_chipselect, avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_chipselect, avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );

endinterface

// File: rtl/pio_debounce_bit.sv
// -----------------------------------------------------------------------------
// pio_debounce_bit
// One input bit: 2-flop synchroniser followed by a stability counter. The
// accepted level only changes after the synchronised input has differed from
// it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   i_pin     asynchronous input (already polarity-corrected)
//   o_sync    synchronised input (debug view)
//   o_stable  debounced level
// -----------------------------------------------------------------------------
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_sync,
  output logic o_stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise, then count consecutive cycles of disagreement with the
  // accepted level. Any cycle of agreement (a bounce back) restarts the count;
  // the last counted cycle both accepts the new level and rearms the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_sync   = r_sync2;
  assign o_stable = r_stable;

endmodule

// File: rtl/avalon_debounced_pio.sv
// -----------------------------------------------------------------------------
// avalon_debounced_pio
// Avalon-MM responder giving the Nios II the input half of a PIO: polarity
// correction, per-bit synchronise + debounce, sticky rising-edge capture with
// write-1-to-clear, an interrupt mask and a registered level interrupt.
// Ports:
//   clk      50 MHz system clock
//   reset    asynchronous active-high reset
//   avs      Avalon-MM slave modport (chipselect/address/read/write/
//            writedata in, readdata/readdatavalid out, read latency 1)
//   pio_in   raw switch/key pins (SW in 7:0, KEY in 9:8)
//   irq      level interrupt, |(edge & mask), registered
// Register map (word address): 0 DATA, 1 IRQMASK, 2 EDGE (W1C), 3 RAW,
//   4 COUNT, 5-7 reserved (read 0).
// Build option: define PIO_EDGE_COUNT_EN to add the 16-bit saturating edge
//   event counter at address 4; otherwise address 4 reads 0.
// -----------------------------------------------------------------------------
module avalon_debounced_pio
  import avalon_pio_pkg::*;
#(
  parameter int               WIDTH           = 10,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] INVERT_MASK     = 10'h300
) (
  input  logic                   clk,
  input  logic                   reset,
  avalon_debounced_pio_if.slave  avs,
  input  logic [WIDTH-1:0]       pio_in,
  output logic                   irq
);

  logic [WIDTH-1:0]  w_x;
  logic [WIDTH-1:0]  w_sync;
  logic [WIDTH-1:0]  w_stable;
  logic [WIDTH-1:0]  w_rise;
  logic [WIDTH-1:0]  w_clr;
  logic [WIDTH-1:0]  w_edge_next;
  logic              w_wr;
  logic              w_rd;
  regsel_e           w_sel;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  logic [WIDTH-1:0]  r_stable_d;
  logic [WIDTH-1:0]  r_edge;
  logic [WIDTH-1:0]  r_mask;
  logic              r_irq;
  logic [DATA_W-1:0] r_readdata;
  logic              r_readdatavalid;

  // Active-low keys are flipped here so everything downstream is active-high
  assign w_x = pio_in ^ INVERT_MASK;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .i_pin    (w_x[gi]),
      .o_sync   (w_sync[gi]),
      .o_stable (w_stable[gi])
    );
  end

  // A write takes priority over a simultaneous read, which then gets no
  // readdatavalid
  assign w_wr  = avs.avs_chipselect && avs.avs_write;
  assign w_rd  = avs.avs_chipselect && avs.avs_read && !w_wr;
  assign w_sel = decodeAddr(avs.avs_address);

  // Upper write-data bits carry no meaning for this block
  assign w_unused = ^avs.avs_writedata;

  // Rising edge of the debounced level; the set term is OR-ed in after the
  // W1C mask so a coincident clear and new edge leave the bit set
  assign w_rise      = w_stable & ~r_stable_d;
  assign w_clr       = (w_wr && w_sel == REG_EDGE) ? avs.avs_writedata[WIDTH-1:0] : '0;
  assign w_edge_next = (r_edge & ~w_clr) | w_rise;

`ifdef PIO_EDGE_COUNT_EN
  logic        w_newset;
  logic [15:0] r_count;

  // One count per cycle in which any edge bit goes from clear to set; a write
  // to the counter address wins over a same-cycle increment
  assign w_newset = |(w_rise & ~r_edge);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_wr && w_sel == REG_COUNT) begin
      r_count <= '0;
    end else if (w_newset && r_count != 16'hFFFF) begin
      r_count <= r_count + 16'd1;
    end
  end
`endif

  // Read mux; unused high bits and reserved addresses return zero
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      REG_DATA:    w_rdata = DATA_W'(w_stable);
      REG_IRQMASK: w_rdata = DATA_W'(r_mask);
      REG_EDGE:    w_rdata = DATA_W'(r_edge);
      REG_RAW:     w_rdata = DATA_W'(w_sync);
`ifdef PIO_EDGE_COUNT_EN
      REG_COUNT:   w_rdata = DATA_W'(r_count);
`else
      REG_COUNT:   w_rdata = '0;
`endif
      default:     w_rdata = '0;
    endcase
  end

  // Register state and bus response. irq is computed from the pre-edge
  // edge/mask values, so it follows any change by one cycle. readdata only
  // reloads on an accepted read and otherwise holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable_d      <= '0;
      r_edge          <= '0;
      r_mask          <= '0;
      r_irq           <= 1'b0;
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_stable_d <= w_stable;
      r_edge     <= w_edge_next;
      if (w_wr && w_sel == REG_IRQMASK) begin
        r_mask <= avs.avs_writedata[WIDTH-1:0];
      end
      r_irq           <= |(r_edge & r_mask);
      r_readdatavalid <= w_rd;
      if (w_rd) begin
        r_readdata <= w_rdata;
      end
    end
  end

  assign avs.avs_readdata      = r_readdata;
  assign avs.avs_readdatavalid = r_readdatavalid;
  assign irq                   = r_irq;

endmodule

// File: tb/tb_avalon_debounced_pio.sv
// -----------------------------------------------------------------------------
// tb_avalon_debounced_pio
// Self-checking bench for avalon_debounced_pio with DEBOUNCE_CYCLES=4 and
// INVERT_MASK=10'h300. A behavioural model (history-window debounce, sticky
// edge set, mask, irq, read port, optional counter) shadows every clock.
// Expected counter values follow PIO_EDGE_COUNT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_avalon_debounced_pio;

  localparam int         DEB = 4;
  localparam logic [9:0] INV = 10'h300;

`ifdef PIO_EDGE_COUNT_EN
  localparam logic [31:0] EXP_CNT_TABLE = 32'd2;
  localparam logic [31:0] EXP_CNT_THREE = 32'd3;
`else
  localparam logic [31:0] EXP_CNT_TABLE = 32'd0;
  localparam logic [31:0] EXP_CNT_THREE = 32'd0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] pioIn;
  logic       irq;
  logic [9:0] curPin;

  int compared = 0;
  int mismatched = 0;

  avalon_debounced_pio_if bus ();

  avalon_debounced_pio #(
    .WIDTH           (10),
    .DEBOUNCE_CYCLES (DEB),
    .INVERT_MASK     (INV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .avs    (bus),
    .pio_in (pioIn),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model. xHist holds the polarity-corrected pin value seen at each
  // clock; the synchronised value in front of a clock is the sample from two
  // clocks earlier. A bit's accepted level flips when the last DEB
  // synchronised samples all disagree with it.
  // ---------------------------------------------------------------------------
  logic [9:0]  xHist[$];
  logic [9:0]  mStable, mEdge, mMask, mRose;
  logic        mIrq, mValid;
  logic [31:0] mData;
  int          mCount;

  task automatic modelReset();
    xHist.delete();
    for (int i = 0; i < 8; i++) xHist.push_back(10'h000);
    mStable = '0; mEdge = '0; mMask = '0; mRose = '0;
    mIrq = 1'b0; mValid = 1'b0; mData = '0; mCount = 0;
  endtask

  function automatic logic [31:0] modelRead(input logic [2:0] addr);
    case (addr)
      3'd0: return {22'd0, mStable};
      3'd1: return {22'd0, mMask};
      3'd2: return {22'd0, mEdge};
      3'd3: return {22'd0, xHist[xHist.size() - 2]};
`ifdef PIO_EDGE_COUNT_EN
      3'd4: return 32'(mCount);
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelStep(input logic cs, input logic rd, input logic wr,
                           input logic [2:0] addr, input logic [31:0] wd,
                           input logic [9:0] pin);
    logic [9:0]  newStable;
    logic [9:0]  clr;
    logic [31:0] rv;
    logic        doWr, doRd, inc;
    doWr = cs && wr;
    doRd = cs && rd && !doWr;
    rv   = modelRead(addr);
    for (int i = 0; i < 10; i++) begin
      logic allDiff;
      allDiff = 1'b1;
      for (int j = 2; j <= DEB + 1; j++)
        if (xHist[xHist.size() - j][i] == mStable[i]) allDiff = 1'b0;
      newStable[i] = allDiff ? ~mStable[i] : mStable[i];
    end
    clr = (doWr && addr == 3'd2) ? wd[9:0] : 10'h000;
    inc = |(mRose & ~mEdge);
`ifdef PIO_EDGE_COUNT_EN
    if (doWr && addr == 3'd4) mCount = 0;
    else if (inc && mCount < 65535) mCount++;
`else
    if (inc) mCount = 0;
`endif
    mIrq  = |(mEdge & mMask);
    mEdge = (mEdge & ~clr) | mRose;
    if (doWr && addr == 3'd1) mMask = wd[9:0];
    mValid = doRd;
    if (doRd) mData = rv;
    mRose   = newStable & ~mStable;
    mStable = newStable;
    xHist.push_back(pin ^ INV);
    if (xHist.size() > 20) void'(xHist.pop_front());
  endtask

  // ---------------------------------------------------------------------------
  // Checking and stimulus tasks
  // ---------------------------------------------------------------------------
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Called at a falling edge: drive, clock, step the model, compare, return
  // at the next falling edge
  task automatic applyStimulus(input logic cs, input logic rd, input logic wr,
                               input logic [2:0] addr, input logic [31:0] wd,
                               input logic [9:0] pin);
    bus.avs_chipselect = cs;
    bus.avs_read       = rd;
    bus.avs_write      = wr;
    bus.avs_address    = addr;
    bus.avs_writedata  = wd;
    pioIn              = pin;
    @(posedge clk);
    modelStep(cs, rd, wr, addr, wd, pin);
    #1;
    checkOutput("model.valid", {31'd0, bus.avs_readdatavalid}, {31'd0, mValid});
    checkOutput("model.rdata", bus.avs_readdata, mData);
    checkOutput("model.irq", {31'd0, irq}, {31'd0, mIrq});
    @(negedge clk);
  endtask

  task automatic doIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, curPin);
  endtask

  task automatic doRead(input logic [2:0] addr);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'd0, curPin);
  endtask

  task automatic doWrite(input logic [2:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, data, curPin);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: one row per clock, hand-derived expectations
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [9:0]  pin;
    logic        cs, rd, wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic        expValid;
    logic [31:0] expData;
    logic        expIrq;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic [9:0] pin, input logic cs, input logic rd,
                        input logic wr, input logic [2:0] addr,
                        input logic [31:0] wd, input logic ev,
                        input logic [31:0] ed, input logic ei);
    vec_t v;
    v.pin = pin; v.cs = cs; v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd;
    v.expValid = ev; v.expData = ed; v.expIrq = ei;
    vecs.push_back(v);
  endtask

  task automatic fillTable();
    addVec(10'h300, 1, 1, 0, 3'd0, 0, 1, 32'h000, 0);                // reset read
    for (int i = 0; i < 5; i++) addVec(10'h301, 0, 0, 0, 3'd0, 0, 0, 32'h000, 0);
    addVec(10'h301, 1, 1, 0, 3'd0, 0, 1, 32'h000, 0);                // not yet
    addVec(10'h301, 1, 1, 0, 3'd0, 0, 1, 32'h001, 0);                // accepted
    addVec(10'h301, 1, 1, 0, 3'd2, 0, 1, 32'h001, 0);                // edge
    for (int i = 0; i < 3; i++) addVec(10'h303, 0, 0, 0, 3'd0, 0, 0, 32'h001, 0);
    for (int i = 0; i < 4; i++) addVec(10'h301, 0, 0, 0, 3'd0, 0, 0, 32'h001, 0);
    addVec(10'h301, 1, 1, 0, 3'd0, 0, 1, 32'h001, 0);                // glitch ignored
    addVec(10'h301, 1, 1, 0, 3'd2, 0, 1, 32'h001, 0);
    for (int i = 0; i < 6; i++) addVec(10'h201, 0, 0, 0, 3'd0, 0, 0, 32'h001, 0);
    addVec(10'h201, 1, 1, 0, 3'd0, 0, 1, 32'h101, 0);                // key pressed
    addVec(10'h201, 1, 1, 0, 3'd2, 0, 1, 32'h101, 0);
    addVec(10'h201, 1, 1, 1, 3'd1, 32'h1, 0, 32'h101, 0);            // write wins
    addVec(10'h201, 1, 1, 0, 3'd1, 0, 1, 32'h001, 1);
    addVec(10'h201, 1, 0, 1, 3'd2, 32'h2, 0, 32'h001, 1);            // other bit
    addVec(10'h201, 1, 1, 0, 3'd2, 0, 1, 32'h101, 1);
    addVec(10'h201, 1, 0, 1, 3'd2, 32'h1, 0, 32'h101, 1);            // W1C bit0
    addVec(10'h201, 0, 0, 0, 3'd0, 0, 0, 32'h101, 0);                // irq drops
    addVec(10'h201, 1, 1, 0, 3'd2, 0, 1, 32'h100, 0);
    addVec(10'h201, 1, 1, 0, 3'd3, 0, 1, 32'h101, 0);                // RAW
    addVec(10'h201, 1, 0, 1, 3'd5, 32'hFFFFFFFF, 0, 32'h101, 0);     // ignored
    addVec(10'h201, 1, 1, 0, 3'd5, 0, 1, 32'h000, 0);
    addVec(10'h201, 1, 1, 0, 3'd4, 0, 1, EXP_CNT_TABLE, 0);
    addVec(10'h201, 0, 1, 0, 3'd0, 0, 0, EXP_CNT_TABLE, 0);          // no select
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    curPin = 10'h300;
    pioIn = curPin;
    bus.avs_chipselect = 1'b0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    bus.avs_address = 3'd0; bus.avs_writedata = 32'd0;
    fillTable();

    repeat (3) @(negedge clk);
    checkOutput("reset.valid", {31'd0, bus.avs_readdatavalid}, 32'd0);
    checkOutput("reset.rdata", bus.avs_readdata, 32'd0);
    checkOutput("reset.irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    modelReset();

    for (int i = 0; i < vecs.size(); i++) begin
      curPin = vecs[i].pin;
      applyStimulus(vecs[i].cs, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, curPin);
      checkOutput($sformatf("vec%0d.valid", i), {31'd0, bus.avs_readdatavalid},
                  {31'd0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d.rdata", i), bus.avs_readdata, vecs[i].expData);
      checkOutput($sformatf("vec%0d.irq", i), {31'd0, irq}, {31'd0, vecs[i].expIrq});
    end

    // Reset in the middle of a read: outputs clear at once, no valid follows
    doWrite(3'd1, 32'h100);
    doIdle(1);
    checkOutput("preReset.irq", {31'd0, irq}, 32'd1);
    doRead(3'd0);
    checkOutput("preReset.rdata", bus.avs_readdata, 32'h101);
    curPin = 10'h300;
    pioIn = curPin;
    bus.avs_chipselect = 1'b1; bus.avs_read = 1'b1; bus.avs_write = 1'b0;
    bus.avs_address = 3'd0;
    #2 reset = 1'b1;
    #1;
    checkOutput("midReset.valid", {31'd0, bus.avs_readdatavalid}, 32'd0);
    checkOutput("midReset.rdata", bus.avs_readdata, 32'd0);
    checkOutput("midReset.irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midReset.noValid", {31'd0, bus.avs_readdatavalid}, 32'd0);
    @(negedge clk);
    bus.avs_chipselect = 1'b0; bus.avs_read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    modelReset();
    doRead(3'd0);
    checkOutput("postReset.valid", {31'd0, bus.avs_readdatavalid}, 32'd1);
    checkOutput("postReset.rdata", bus.avs_readdata, 32'd0);
    doIdle(1);
    checkOutput("postReset.validDrop", {31'd0, bus.avs_readdatavalid}, 32'd0);

    // Three separate rising edges on fresh bits, then clear the counter
    for (int b = 2; b <= 4; b++) begin
      curPin = curPin | (10'd1 << b);
      doIdle(8);
    end
    doRead(3'd4);
    checkOutput("count.three", bus.avs_readdata, EXP_CNT_THREE);
    doWrite(3'd4, 32'd0);
    doRead(3'd4);
    checkOutput("count.cleared", bus.avs_readdata, 32'd0);

    // Set wins: a W1C of bit 0 lands in the same cycle as a new bit-0 edge
    doWrite(3'd2, 32'h3FF);
    doWrite(3'd1, 32'h001);
    curPin = curPin | 10'd1;
    doIdle(8);
    checkOutput("setWins.irqArmed", {31'd0, irq}, 32'd1);
    curPin = curPin & ~10'd1;
    doIdle(8);
    curPin = curPin | 10'd1;
    doIdle(6);
    doWrite(3'd2, 32'h001);
    checkOutput("setWins.irqAtW1C", {31'd0, irq}, 32'd1);
    doIdle(1);
    checkOutput("setWins.irqAfter", {31'd0, irq}, 32'd1);
    doRead(3'd2);
    checkOutput("setWins.edge", bus.avs_readdata, 32'h001);

    // Randomised traffic with bouncing pins, checked against the model
    for (int c = 0; c < 800; c++) begin
      int op;
      logic cs;
      logic [2:0] addr;
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = $urandom_range(0, 9);
        curPin[b] = ~curPin[b];
      end
      op   = $urandom_range(0, 99);
      cs   = ($urandom_range(0, 9) != 0);
      addr = 3'($urandom_range(0, 7));
      if (op < 35)      applyStimulus(cs, 1'b1, 1'b0, addr, 32'd0, curPin);
      else if (op < 47) applyStimulus(cs, 1'b0, 1'b1, addr, $urandom, curPin);
      else if (op < 52) applyStimulus(cs, 1'b1, 1'b1, addr, $urandom, curPin);
      else              applyStimulus(1'b0, 1'b0, 1'b0, addr, 32'd0, curPin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete, compared=%0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
